fq_release_buffer: RTL
======================

# fq_release_buffer

Timestamped flit holding buffer placed directly downstream of the flow-queue bandwidth control unit. It accepts a flit together with the departure timestamp computed by that unit, stores it in arrival order, and releases it to the link/router stage only once simulated time has reached that timestamp. This turns the control unit's computed timestamps into actual release timing, with a valid/ready handshake on both sides.

## Interface
- `TS_WIDTH`, 10, timestamp width; must match the control unit's timestamp width.
- `DATA_WIDTH`, 36, flit payload width.
- `DEPTH`, 4, number of buffer entries; power of two, ≥2.
- `clock` in 1: single clock; everything is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sim_time` in TS_WIDTH: current simulated time.
- `in_valid` in 1: flit offered.
- `in_data` in DATA_WIDTH: flit payload.
- `in_timestamp` in TS_WIDTH: departure time from the bandwidth control unit.
- `in_ready` out 1: buffer can accept; equals `!full`.
- `out_valid` out 1: output register holds a due flit.
- `out_data` out DATA_WIDTH: released payload.
- `out_timestamp` out TS_WIDTH: timestamp of released flit.
- `out_ready` in 1: consumer accepts.
- `count` out clog2(DEPTH)+1: entries in buffer, excluding the output register.
- `order_err` out 1: sticky flag for a non-monotonic input timestamp.

## Operation
- Enqueue on an edge with `in_valid && in_ready`. Write {data, ts} at `wr_ptr`, then advance `wr_ptr`.
- `in_ready` is derived from the current `count` only. A pop in the same cycle does not free a slot for the push, so there is no same-cycle full bypass.
- Due test is wrap-aware: the head is due when `(sim_time - head_ts) mod 2^TS_WIDTH < 2^(TS_WIDTH-1)`. This test belongs in the shared package.
- Output register load:
  - Condition: buffer not empty, head is due, and (`!out_valid` or `out_ready`).
  - Action: load head into `out_data`/`out_timestamp`, set `out_valid`, advance `rd_ptr`.
- `out_valid && out_ready` with no load in the same edge: clear `out_valid`.
- Output FSM:
  - IDLE: buffer and output register empty.
  - WAIT: head present but not due, output register empty.
  - HOLD: `out_valid` = 1.
- FSM transitions:
  - IDLE→WAIT on a push of a not-due flit.
  - IDLE→HOLD is impossible directly; a flit must first be written.
  - WAIT→HOLD on a load.
  - HOLD→HOLD on a handshake with a back-to-back load.
  - HOLD→WAIT/IDLE on a handshake without a load, depending on buffer state.
- Order checking:
  - `last_in_ts` is updated on every push.
  - On a push whose ts is older than `last_in_ts` (same wrap-aware compare, strict), set `order_err`. It stays set until reset.
  - The flit is still enqueued normally.
- `count` is incremented on push and decremented on load; both in one edge leaves it unchanged.
- Pointers are clog2(DEPTH)+1 bits; full/empty are decided by the MSB compare.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_timestamp`=0, `count`=0, `in_ready`=1, `order_err`=0, pointers=0, `last_in_ts`=0, FSM=IDLE.
- Assertion of `reset_n` takes effect immediately and discards all contents mid-operation. Deassertion is synchronous to `clock` by the system.
- Latency: a flit pushed at edge k with ts already due gives `out_valid`=1 after edge k+1 (one cycle in buffer). A not-due flit gives `out_valid` after the first edge at which `sim_time` satisfies the due test.
- Throughput: one release per cycle while flits are due and `out_ready`=1.
- `out_data`/`out_timestamp` stay stable while `out_valid && !out_ready`.
- Release is strictly FIFO; a due flit behind a not-due head waits.

## Structure
- Shared package/header contents: `TS_WIDTH`, `ts_due(now, ts)` wrap-compare function, `ts_older(a, b)` function.
- Sub-module `fq_ts_fifo`:
  - Parameterised storage with pointers, `count`, full/empty, push/pop ports.
  - `fq_release_buffer` adds the due test, output register, FSM and order check.

## Test plan
- Reset then push ts=5 at `sim_time`=5 with `out_ready`=1 → `out_valid` one cycle after the push, `out_timestamp`=5, `count` returns to 0.
- Push ts=20 at `sim_time`=10 and hold `sim_time` → `out_valid` stays 0; step `sim_time` to 20 → released next edge.
- Push DEPTH flits all not due → `in_ready`=0 and `count`=4. Make all flits due with `out_ready`=1 → releases on 4 consecutive cycles in push order.
- Wrap: `sim_time`=1020, push ts=2 (TS_WIDTH=10) → not due until `sim_time` wraps to 2, then released.
- Push ts=30 then ts=25 → `order_err`=1 sticky, and both flits are still released in push order.
- Assert `reset_n` low while `out_valid`=1 and `count`=3 → all outputs immediately return to reset values.

Source files
------------

// File: rtl/fq_release_buffer_pkg.sv
// Shared timestamp definitions for the flow-queue release buffer.
// The due and order tests treat timestamps as points on a wrapping circle.
package fq_release_buffer_pkg;

   localparam int TS_WIDTH = 10;

   typedef logic [TS_WIDTH-1:0] ts_t;

   // A timestamp is due when it lies in the half-circle at or behind 'now'.
   function automatic logic ts_due(input ts_t now, input ts_t ts);
      ts_t diff;
      diff = now - ts;
      return !diff[TS_WIDTH-1];
   endfunction

   // Strictly older: a is behind b on the circle and not equal to b.
   function automatic logic ts_older(input ts_t a, input ts_t b);
      return (a != b) && ts_due(b, a);
   endfunction

endpackage

// File: rtl/fq_release_buffer_if.sv
// Ingress and egress valid/ready streams of the release buffer.
interface fq_release_buffer_if #(
   parameter int DATA_WIDTH = 36,
   parameter int TS_WIDTH   = fq_release_buffer_pkg::TS_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [TS_WIDTH-1:0]   in_timestamp;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [TS_WIDTH-1:0]   out_timestamp;

   modport slave (
      input  in_valid, in_data, in_timestamp, out_ready,
      output in_ready, out_valid, out_data, out_timestamp
   );

   modport master (
      output in_valid, in_data, in_timestamp, out_ready,
      input  in_ready, out_valid, out_data, out_timestamp
   );
endinterface

// File: rtl/fq_ts_fifo.sv
// Arrival-order storage for {payload, timestamp} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fq_ts_fifo #(
   parameter int WIDTH = 46,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + CW'(do_push);
      rd_ptr_d = rd_ptr_q + CW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; entries are only visible between the pointers.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/fq_release_buffer.sv
// Holds timestamped flits in arrival order and releases each one only
// once sim_time has reached its departure timestamp.
module fq_release_buffer
   import fq_release_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 36,
   parameter int DEPTH      = 4,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  ts_t                  sim_time,
   fq_release_buffer_if.slave   bus,
   output logic [CW-1:0]        count,
   output logic                 order_err
);
   localparam int EW = DATA_WIDTH + TS_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   ts_t                   out_ts_q, out_ts_d;
   ts_t                   last_in_ts_q, last_in_ts_d;
   logic                  order_err_q, order_err_d;

   logic [EW-1:0]         head;
   logic [DATA_WIDTH-1:0] head_data;
   ts_t                   head_ts;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic                  push, load, handshake, out_valid;

   fq_ts_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i ({bus.in_data, bus.in_timestamp}),
      .pop_i       (load),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign {head_data, head_ts} = head;

   // in_ready looks only at the stored count; a same-cycle release never frees a slot.
   assign push      = bus.in_valid && !fifo_full;
   assign out_valid = (state_q == S_HOLD);
   assign handshake = out_valid && bus.out_ready;
   assign load      = !fifo_empty && ts_due(sim_time, head_ts) &&
                      (!out_valid || bus.out_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = push ? S_WAIT : S_IDLE;
         S_WAIT:  state_d = load ? S_HOLD : S_WAIT;
         S_HOLD: begin
            if (load)           state_d = S_HOLD;
            else if (handshake) state_d = (fifo_empty && !push) ? S_IDLE : S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_data_d   = load ? head_data : out_data_q;
      out_ts_d     = load ? head_ts   : out_ts_q;
      last_in_ts_d = push ? bus.in_timestamp : last_in_ts_q;
      order_err_d  = order_err_q ||
                     (push && ts_older(bus.in_timestamp, last_in_ts_q));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         out_data_q   <= '0;
         out_ts_q     <= '0;
         last_in_ts_q <= '0;
         order_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_ts_q     <= out_ts_d;
         last_in_ts_q <= last_in_ts_d;
         order_err_q  <= order_err_d;
      end
   end

   assign bus.in_ready      = !fifo_full;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = out_data_q;
   assign bus.out_timestamp = out_ts_q;
   assign count             = fifo_count;
   assign order_err         = order_err_q;

endmodule
